// File: rtl/maclaurin_if.sv
// Start/done handshake and operand/result bus for the Maclaurin series engine.
interface maclaurin_if #(
  parameter int W  = 16,
  parameter int RW = W + 2
);
  logic          start;
  logic          mode;
  logic [W-1:0]  xBus;
  logic [RW-1:0] rBus;
  logic          done;
  logic          busy;

  modport master (output start, output mode, output xBus, input rBus, input done, input busy);
  modport slave  (input start, input mode, input xBus, output rBus, output done, output busy);
endinterface

// File: rtl/maclaurin_engine.sv
// Sequential ln(1+x) / exp(x) Maclaurin evaluator: one multiplier, one term per two cycles.
// Define MACLAURIN_SAT_EN for saturating arithmetic; otherwise everything wraps.
module maclaurin_engine #(
  parameter int W     = 16,
  parameter int FRAC  = 14,
  parameter int RW    = W + 2,
  parameter int IW    = W + 8,
  parameter int TERMS = 8
) (
  input  logic       clk,
  input  logic       rst,
  maclaurin_if.slave bus
);

  if (TERMS < 1 || TERMS > 16) begin : g_terms_chk
    $error("maclaurin_engine: TERMS must lie in 1..16");
  end

`ifdef MACLAURIN_SAT_EN
  localparam int LW = 2 * IW;
  localparam int AW = IW + 1;
`else
  localparam int LW = IW + FRAC;
  localparam int AW = IW;
`endif
  localparam int SW = LW - FRAC;
  localparam int KW = $clog2(TERMS + 2);
  localparam logic signed [IW-1:0] ONE = IW'(1 << FRAC);

  typedef enum logic [1:0] {IDLE, MULX, MULR, FIN} state_e;

  state_e               state_q, state_d;
  logic signed [W-1:0]  x_q, x_d;
  logic                 mode_q, mode_d;
  logic signed [IW-1:0] p_q, p_d;
  logic signed [IW-1:0] acc_q, acc_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [RW-1:0] r_q, r_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [FRAC:0]        recip_rom [2**KW];
  logic signed [LW-1:0] p_ext, x_ext, r_ext;
  logic signed [SW-1:0] px_sh, term_sh;
  logic signed [IW-1:0] px_red, term, acc_new;
  logic signed [AW-1:0] acc_sum;
  logic signed [RW-1:0] r_next;
  logic                 sub;

  // 1/k table, floor(2^FRAC / k); entry 0 is never addressed
  for (genvar g = 0; g < 2**KW; g++) begin : g_rom
    if (g == 0) begin : g_zero
      assign recip_rom[g] = '0;
    end else begin : g_val
      assign recip_rom[g] = (FRAC+1)'((1 << FRAC) / g);
    end
  end

`ifdef MACLAURIN_SAT_EN
  localparam logic signed [SW-1:0] IW_MAX = SW'({1'b0, {(IW-1){1'b1}}});
  localparam logic signed [SW-1:0] IW_MIN = ~IW_MAX;
  localparam logic signed [IW-1:0] RW_MAX = IW'({1'b0, {(RW-1){1'b1}}});
  localparam logic signed [IW-1:0] RW_MIN = ~RW_MAX;

  function automatic logic signed [IW-1:0] sat_iw(input logic signed [SW-1:0] v);
    if (v > IW_MAX)      sat_iw = {1'b0, {(IW-1){1'b1}}};
    else if (v < IW_MIN) sat_iw = {1'b1, {(IW-1){1'b0}}};
    else                 sat_iw = v[IW-1:0];
  endfunction

  function automatic logic signed [RW-1:0] sat_rw(input logic signed [IW-1:0] v);
    if (v > RW_MAX)      sat_rw = {1'b0, {(RW-1){1'b1}}};
    else if (v < RW_MIN) sat_rw = {1'b1, {(RW-1){1'b0}}};
    else                 sat_rw = v[RW-1:0];
  endfunction
`endif

  assign p_ext   = LW'(p_q);
  assign x_ext   = LW'(x_q);
  assign r_ext   = LW'($signed({1'b0, recip_rom[k_q]}));
  assign px_sh   = SW'((p_ext * x_ext) >>> FRAC);
  assign term_sh = SW'((p_ext * r_ext) >>> FRAC);
  // ln alternates sign: even-k terms are subtracted
  assign sub     = ~mode_q & ~k_q[0];

`ifdef MACLAURIN_SAT_EN
  assign px_red  = sat_iw(px_sh);
  assign term    = sat_iw(term_sh);
  assign acc_sum = sub ? (AW'(acc_q) - AW'(term)) : (AW'(acc_q) + AW'(term));
  assign acc_new = sat_iw(SW'(acc_sum));
  assign r_next  = sat_rw(acc_q);
`else
  assign px_red  = px_sh;
  assign term    = term_sh;
  assign acc_sum = sub ? (acc_q - term) : (acc_q + term);
  assign acc_new = acc_sum;
  assign r_next  = acc_q[RW-1:0];
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mode_d  = mode_q;
    p_d     = p_q;
    acc_d   = acc_q;
    k_d     = k_q;
    r_d     = r_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.xBus;
          mode_d  = bus.mode;
          k_d     = KW'(1);
          p_d     = ONE;
          acc_d   = bus.mode ? ONE : '0;
          busy_d  = 1'b1;
          state_d = MULX;
        end
      end
      MULX: begin
        p_d     = px_red;
        state_d = MULR;
      end
      MULR: begin
        acc_d   = acc_new;
        if (mode_q) p_d = term;
        k_d     = k_q + KW'(1);
        state_d = (k_q < KW'(TERMS)) ? MULX : FIN;
      end
      FIN: begin
        r_d     = r_next;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      mode_q  <= 1'b0;
      p_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      r_q     <= r_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.rBus = r_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_maclaurin_engine.sv
// Scoreboard bench for maclaurin_engine: directed plan cases plus randomized operands.
module tb_maclaurin_engine;
  localparam int W = 16, FRAC = 14, RW = 18, IW = 24, T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  typedef struct { int done_cyc; logic [RW-1:0] r; } sb_item_t;
  sb_item_t sbq[$];

  int            busy_lo = 0;
  int            busy_hi = -1;
  logic [RW-1:0] held = '0;
  logic [RW-1:0] last_r = '0;
  logic          rst_prev = 1'b0;

  maclaurin_if #(.W(W), .RW(RW)) bus ();

  maclaurin_engine #(.W(W), .FRAC(FRAC), .RW(RW), .IW(IW), .TERMS(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_tol(input string name, input logic [RW-1:0] act, input int target, input int tol);
    int a, d;
    a = int'($signed(act));
    d = a - target;
    checks++;
    if (d >= -tol && d <= tol) passes++;
    else $display("FAIL %s: got %0h, expected %0h +/- %0d (cycle %0d)", name, act, target, tol, cyc);
  endtask

  // Reference arithmetic: reduce a value to the internal IW-bit range
  function automatic longint red(input longint v);
    longint m, w;
    m = longint'(1) << IW;
`ifdef MACLAURIN_SAT_EN
    if (v > m/2 - 1) return m/2 - 1;
    if (v < -(m/2))  return -(m/2);
    return v;
`else
    w = v & (m - 1);
    if (w >= m/2) w = w - m;
    return w;
`endif
  endfunction

  function automatic logic [RW-1:0] to_rbus(input longint acc);
    longint m;
    m = longint'(1) << RW;
`ifdef MACLAURIN_SAT_EN
    if (acc > m/2 - 1) acc = m/2 - 1;
    if (acc < -(m/2))  acc = -(m/2);
`endif
    return RW'(acc & (m - 1));
  endfunction

  // Series sum: ln(1+x) = sum (-1)^(k+1) x^k/k ; exp(x) = 1 + sum x^k/k!
  function automatic logic [RW-1:0] model(input logic m, input logic [W-1:0] x);
    longint xs, p, acc, term;
    xs  = longint'($signed(x));
    p   = longint'(1) << FRAC;
    acc = m ? (longint'(1) << FRAC) : 0;
    for (int k = 1; k <= T; k++) begin
      p    = red((p * xs) >>> FRAC);
      term = red((p * ((longint'(1) << FRAC) / k)) >>> FRAC);
      if (m || (k % 2 == 1)) acc = red(acc + term);
      else                   acc = red(acc - term);
      if (m) p = term;
    end
    return to_rbus(acc);
  endfunction

  // Monitor: checks done/result against the scoreboard, busy window and rBus hold
  always @(negedge clk) begin
    sb_item_t it;
    logic exp_busy;
    if (rst_prev) held = '0;
    if (sbq.size() != 0 && cyc == sbq[0].done_cyc) begin
      it = sbq.pop_front();
      chk("done_pulse", 32'(bus.done), 32'd1);
      chk("rBus_result", 32'(bus.rBus), 32'(it.r));
      held   = it.r;
      last_r = bus.rBus;
    end else begin
      chk("done_idle", 32'(bus.done), 32'd0);
      chk("rBus_hold", 32'(bus.rBus), 32'(held));
    end
    exp_busy = (cyc >= busy_lo && cyc <= busy_hi);
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    rst_prev = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic issue(input logic m, input logic [W-1:0] x);
    sb_item_t it;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.xBus  = x;
    if (cyc > busy_hi) begin
      it.done_cyc = cyc + 2*T + 2;
      it.r        = model(m, x);
      sbq.push_back(it);
      busy_lo = cyc + 1;
      busy_hi = cyc + 2*T + 1;
    end
    tick();
    bus.start = 1'b0;
    bus.mode  = 1'($urandom_range(0, 1));
    bus.xBus  = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc <= busy_hi + 1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (cyc > busy_hi + 1) passes++;
    else $display("FAIL wait_idle: bound expired at cycle %0d", cyc);
  endtask

  initial begin
    int c;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.xBus  = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_rBus", 32'(bus.rBus), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);

    // exp(0) = 1.0, done exactly 2*T+2 cycles after start
    c = cyc;
    issue(1'b1, 16'h0000);
    wait_idle();
    chk("exp0_value", 32'(last_r), 32'h04000);
    chk("exp0_latency", 32'(busy_hi + 1 - c), 32'(2*T + 2));

    issue(1'b0, 16'h2000);
    wait_idle();
    chk_tol("ln1p5_tol", last_r, 'h019F0, 8);

    issue(1'b1, 16'h4000);
    wait_idle();
    chk_tol("exp1_tol", last_r, 'h0ADF8, 8);

    issue(1'b0, 16'h8000);
    wait_idle();
`ifdef MACLAURIN_SAT_EN
    chk("ln_neg2_sat", 32'(last_r), 32'h20000);
`else
    chk("ln_neg2_wrap", 32'(last_r), 32'(model(1'b0, 16'h8000)));
`endif

    // start re-pulsed while busy is ignored; start in the done cycle is accepted
    c = cyc;
    issue(1'b0, 16'h1234);
    goto_cyc(c + 3);
    issue(1'b1, 16'h3000);
    goto_cyc(c + 10);
    issue(1'b1, 16'h7FFF);
    goto_cyc(busy_hi + 1);
    issue(1'b1, 16'hE000);
    wait_idle();

    // reset mid-operation aborts with no done pulse
    c = cyc;
    issue(1'b1, 16'h2000);
    goto_cyc(c + 7);
    rst = 1'b1;
    sbq.delete();
    busy_hi = cyc;
    tick();
    rst = 1'b0;
    chk("rst_abort_busy", 32'(bus.busy), 32'd0);
    chk("rst_abort_done", 32'(bus.done), 32'd0);
    goto_cyc(c + 25);
    issue(1'b0, 16'hF000);
    wait_idle();

    // randomized operands, mixing back-to-back and spaced starts
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      goto_cyc(busy_hi + 1 + gap);
      issue(1'($urandom_range(0, 1)), W'($urandom));
    end
    wait_idle();
    repeat (3) tick();
    chk("queue_empty", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
